// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM download loader: FSM states,
// region select bit positions, default region bases and ioctl indices.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } loader_state_t;

    // Bit positions inside the one-hot rom_sel vector {pal,gfx,snd,cpu}
    localparam int REGION_CPU = 0;
    localparam int REGION_SND = 1;
    localparam int REGION_GFX = 2;
    localparam int REGION_PAL = 3;

    // Default byte offsets of each region inside the downloaded image
    localparam logic [26:0] DEF_CPU_BASE = 27'h00000;
    localparam logic [26:0] DEF_SND_BASE = 27'h10000;
    localparam logic [26:0] DEF_GFX_BASE = 27'h18000;
    localparam logic [26:0] DEF_PAL_BASE = 27'h50000;
    localparam logic [26:0] DEF_END_ADDR = 27'h50400;

    // ioctl index values
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational image-address to region decoder: one-hot select, offset
// relative to the region base (18 bits), and a valid flag for in-image bytes.
module rom_region_decode
    import loader_pkg::*;
#(
    parameter logic [26:0] CPU_BASE = DEF_CPU_BASE,
    parameter logic [26:0] SND_BASE = DEF_SND_BASE,
    parameter logic [26:0] GFX_BASE = DEF_GFX_BASE,
    parameter logic [26:0] PAL_BASE = DEF_PAL_BASE,
    parameter logic [26:0] END_ADDR = DEF_END_ADDR
) (
    input  logic [26:0] addr,
    output logic [3:0]  sel,
    output logic [17:0] rel_addr,
    output logic        valid
);

    // Region lookup; the subtraction is done modulo 2^18 which equals the
    // truncated full-width difference.
    always_comb begin
        sel      = 4'b0000;
        rel_addr = 18'd0;
        valid    = 1'b0;
        if (addr < SND_BASE) begin
            sel[REGION_CPU] = 1'b1;
            rel_addr        = addr[17:0] - CPU_BASE[17:0];
            valid           = 1'b1;
        end else if (addr < GFX_BASE) begin
            sel[REGION_SND] = 1'b1;
            rel_addr        = addr[17:0] - SND_BASE[17:0];
            valid           = 1'b1;
        end else if (addr < PAL_BASE) begin
            sel[REGION_GFX] = 1'b1;
            rel_addr        = addr[17:0] - GFX_BASE[17:0];
            valid           = 1'b1;
        end else if (addr < END_ADDR) begin
            sel[REGION_PAL] = 1'b1;
            rel_addr        = addr[17:0] - PAL_BASE[17:0];
            valid           = 1'b1;
        end else begin
            sel      = 4'b0000;
            rel_addr = 18'd0;
            valid    = 1'b0;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Splits 16-bit HPS ioctl download words into two byte writes towards the
// game ROM regions, captures DIP switch bytes, and sequences core reset.
module rom_loader #(
    parameter logic [26:0] CPU_BASE = loader_pkg::DEF_CPU_BASE,
    parameter logic [26:0] SND_BASE = loader_pkg::DEF_SND_BASE,
    parameter logic [26:0] GFX_BASE = loader_pkg::DEF_GFX_BASE,
    parameter logic [26:0] PAL_BASE = loader_pkg::DEF_PAL_BASE,
    parameter logic [26:0] END_ADDR = loader_pkg::DEF_END_ADDR
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [17:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_we,
    output logic [3:0]  rom_sel,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1,
    output logic        load_done,
    output logic        core_reset
);
    import loader_pkg::*;

    loader_state_t state_r;
    logic [26:0]   addr_r;
    logic [7:0]    data_hi_r;
    logic          dl_prev_r;
    logic          done_pend_r;

    logic [26:0]   dec_addr_s;
    logic [3:0]    dec_sel_s;
    logic [17:0]   dec_rel_s;
    logic          dec_valid_s;
    logic          dl_s;
    logic          dl_rise_s;
    logic          dl_fall_s;
    logic          rom_wr_s;
    logic          dip_wr_s;

    assign dl_s      = ioctl_download & (ioctl_index == IDX_ROM);
    assign dl_rise_s = dl_s & ~dl_prev_r;
    assign dl_fall_s = ~dl_s & dl_prev_r;
    assign rom_wr_s  = ioctl_wr & dl_s;
    assign dip_wr_s  = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[24:3] == 22'd0);

    // Decoder input: the incoming word address when a new word arrives,
    // otherwise the odd byte of the latched word.
    always_comb begin
        dec_addr_s = ioctl_addr;
        if (state_r == ST_IDLE) begin
            dec_addr_s = ioctl_addr;
        end else begin
            dec_addr_s = addr_r + 27'd1;
        end
    end

    rom_region_decode #(
        .CPU_BASE (CPU_BASE),
        .SND_BASE (SND_BASE),
        .GFX_BASE (GFX_BASE),
        .PAL_BASE (PAL_BASE),
        .END_ADDR (END_ADDR)
    ) u_decode (
        .addr     (dec_addr_s),
        .sel      (dec_sel_s),
        .rel_addr (dec_rel_s),
        .valid    (dec_valid_s)
    );

    // Word-split FSM; the low byte is issued on the latch edge so the first
    // strobe appears one cycle after ioctl_wr, the high byte one cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= 27'd0;
            data_hi_r  <= 8'd0;
            ioctl_wait <= 1'b0;
            rom_we     <= 1'b0;
            rom_sel    <= 4'b0000;
            rom_addr   <= 18'd0;
            rom_data   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rom_wr_s) begin
                        addr_r     <= ioctl_addr;
                        data_hi_r  <= ioctl_dout[15:8];
                        rom_we     <= dec_valid_s;
                        rom_sel    <= dec_sel_s;
                        rom_addr   <= dec_rel_s;
                        rom_data   <= ioctl_dout[7:0];
                        ioctl_wait <= 1'b1;
                        state_r    <= ST_WR_LO;
                    end else begin
                        rom_we     <= 1'b0;
                        rom_sel    <= 4'b0000;
                        ioctl_wait <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_WR_LO: begin
                    rom_we     <= dec_valid_s;
                    rom_sel    <= dec_sel_s;
                    rom_addr   <= dec_rel_s;
                    rom_data   <= data_hi_r;
                    ioctl_wait <= 1'b1;
                    state_r    <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    rom_we     <= 1'b0;
                    rom_sel    <= 4'b0000;
                    ioctl_wait <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    rom_we     <= 1'b0;
                    rom_sel    <= 4'b0000;
                    ioctl_wait <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // DIP switch byte capture from index-254 writes to bytes 0 and 1.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dsw0 <= 8'hFF;
            dsw1 <= 8'hFF;
        end else if (dip_wr_s) begin
            case (ioctl_addr[2:0])
                3'd0:    dsw0 <= ioctl_dout[7:0];
                3'd1:    dsw1 <= ioctl_dout[7:0];
                default: dsw0 <= dsw0;
            endcase
        end else begin
            dsw0 <= dsw0;
            dsw1 <= dsw1;
        end
    end

    // Download completion tracking; an end of download seen mid-word is held
    // pending until the last byte has been written.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_prev_r   <= 1'b0;
            done_pend_r <= 1'b0;
            load_done   <= 1'b0;
            core_reset  <= 1'b1;
        end else begin
            dl_prev_r  <= dl_s;
            core_reset <= ~load_done | dl_s | (state_r != ST_IDLE);
            if (dl_rise_s) begin
                load_done   <= 1'b0;
                done_pend_r <= 1'b0;
            end else if ((state_r == ST_IDLE) && (dl_fall_s || done_pend_r)) begin
                load_done   <= 1'b1;
                done_pend_r <= 1'b0;
            end else if (dl_fall_s) begin
                done_pend_r <= 1'b1;
            end else begin
                done_pend_r <= done_pend_r;
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed testbench for rom_loader with hand-computed expected values.
module tb_rom_loader;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we;
    logic [3:0]  rom_sel;
    logic [7:0]  dsw0;
    logic [7:0]  dsw1;
    logic        load_done;
    logic        core_reset;

    int checks_cnt;
    int errors_cnt;

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .rom_sel        (rom_sel),
        .dsw0           (dsw0),
        .dsw1           (dsw1),
        .load_done      (load_done),
        .core_reset     (core_reset)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One ROM word: checks both byte strobes and the two-cycle wait pulse.
    task automatic write_word(input logic [26:0] addr, input logic [15:0] data,
                              input logic valid, input logic [3:0] sel,
                              input logic [17:0] rel);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = data;
        tick();
        ioctl_wr = 1'b0;
        check_val("we_lo", rom_we, valid);
        check_val("sel_lo", rom_sel, valid ? sel : 4'b0000);
        check_val("wait_c1", ioctl_wait, 1'b1);
        if (valid) begin
            check_val("addr_lo", rom_addr, rel);
            check_val("data_lo", rom_data, data[7:0]);
        end
        tick();
        check_val("we_hi", rom_we, valid);
        check_val("sel_hi", rom_sel, valid ? sel : 4'b0000);
        check_val("wait_c2", ioctl_wait, 1'b1);
        if (valid) begin
            check_val("addr_hi", rom_addr, rel + 18'd1);
            check_val("data_hi", rom_data, data[15:8]);
        end
        tick();
        check_val("we_c3", rom_we, 1'b0);
        check_val("wait_c3", ioctl_wait, 1'b0);
    endtask

    initial begin
        checks_cnt     = 0;
        errors_cnt     = 0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 27'd0;
        ioctl_dout     = 16'd0;
        tick();
        tick();
        check_val("rst_wait", ioctl_wait, 1'b0);
        check_val("rst_we", rom_we, 1'b0);
        check_val("rst_sel", rom_sel, 4'b0000);
        check_val("rst_addr", rom_addr, 18'd0);
        check_val("rst_data", rom_data, 8'd0);
        check_val("rst_done", load_done, 1'b0);
        check_val("rst_creset", core_reset, 1'b1);
        check_val("rst_dsw0", dsw0, 8'hFF);
        check_val("rst_dsw1", dsw1, 8'hFF);
        reset = 1'b0;

        // ROM download, words across all regions and the boundaries
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        tick();
        write_word(27'h00010, 16'hA55A, 1'b1, 4'b0001, 18'h00010);
        write_word(27'h10004, 16'h1357, 1'b1, 4'b0010, 18'h00004);
        write_word(27'h17FFE, 16'h2468, 1'b1, 4'b0010, 18'h07FFE);
        write_word(27'h18002, 16'hC33C, 1'b1, 4'b0100, 18'h00002);
        write_word(27'h4FFFE, 16'h0F0F, 1'b1, 4'b0100, 18'h37FFE);
        write_word(27'h503FE, 16'h9876, 1'b1, 4'b1000, 18'h003FE);
        write_word(27'h50400, 16'hDEAD, 1'b0, 4'b0000, 18'h00000);
        check_val("dl_done_low", load_done, 1'b0);
        check_val("dl_creset", core_reset, 1'b1);

        // Write strobe while busy is ignored
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h00020;
        ioctl_dout = 16'h1122;
        tick();
        ioctl_addr = 27'h00040;
        ioctl_dout = 16'h3344;
        check_val("busy_lo_data", rom_data, 8'h22);
        tick();
        ioctl_wr = 1'b0;
        check_val("busy_hi_addr", rom_addr, 18'h00021);
        check_val("busy_hi_data", rom_data, 8'h11);
        tick();
        check_val("busy_c3_we", rom_we, 1'b0);
        check_val("busy_c3_wait", ioctl_wait, 1'b0);
        tick();
        check_val("busy_c4_we", rom_we, 1'b0);

        // Download drops during WR_LO
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h00030;
        ioctl_dout = 16'hBEEF;
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        check_val("drop_lo_data", rom_data, 8'hEF);
        tick();
        check_val("drop_hi_we", rom_we, 1'b1);
        check_val("drop_hi_addr", rom_addr, 18'h00031);
        check_val("drop_hi_data", rom_data, 8'hBE);
        check_val("drop_done_c2", load_done, 1'b0);
        tick();
        check_val("drop_idle_we", rom_we, 1'b0);
        check_val("drop_done_c3", load_done, 1'b0);
        tick();
        check_val("drop_done_c4", load_done, 1'b1);
        check_val("drop_creset_c4", core_reset, 1'b1);
        tick();
        check_val("drop_creset_c5", core_reset, 1'b0);

        // DIP switch capture
        ioctl_download = 1'b1;
        ioctl_index    = 8'd254;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 27'd0;
        ioctl_dout     = 16'h0012;
        tick();
        check_val("dip_wait0", ioctl_wait, 1'b0);
        check_val("dip_we0", rom_we, 1'b0);
        ioctl_addr = 27'd1;
        ioctl_dout = 16'h0034;
        tick();
        check_val("dip_wait1", ioctl_wait, 1'b0);
        ioctl_addr = 27'd8;
        ioctl_dout = 16'h0099;
        tick();
        ioctl_wr = 1'b0;
        check_val("dip_wait2", ioctl_wait, 1'b0);
        check_val("dsw0_val", dsw0, 8'h12);
        check_val("dsw1_val", dsw1, 8'h34);
        check_val("dip_done", load_done, 1'b1);
        check_val("dip_creset", core_reset, 1'b0);

        // New ROM download clears load_done
        ioctl_index = 8'd0;
        tick();
        check_val("redl_done", load_done, 1'b0);
        tick();
        check_val("redl_creset", core_reset, 1'b1);

        // Reset in WR_LO abandons the high byte
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h00050;
        ioctl_dout = 16'h7788;
        tick();
        ioctl_wr = 1'b0;
        check_val("mid_we_lo", rom_we, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_we", rom_we, 1'b0);
        check_val("mid_wait", ioctl_wait, 1'b0);
        check_val("mid_dsw0", dsw0, 8'hFF);
        check_val("mid_dsw1", dsw1, 8'hFF);
        check_val("mid_done", load_done, 1'b0);
        check_val("mid_creset", core_reset, 1'b1);
        tick();
        check_val("mid_we_after", rom_we, 1'b0);
        check_val("mid_wait_after", ioctl_wait, 1'b0);
        ioctl_download = 1'b0;
        tick();
        tick();
        check_val("end_done", load_done, 1'b1);
        tick();
        check_val("end_creset", core_reset, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter CPU_BASE, default 27'h00000, byte offset of main-CPU ROM region.
REQ-002 Parameter SND_BASE, default 27'h10000, byte offset of sound-CPU ROM region.
REQ-003 Parameter GFX_BASE, default 27'h18000, byte offset of graphics ROM region.
REQ-004 Parameter PAL_BASE, default 27'h50000, byte offset of palette/PROM region; END_ADDR, default 27'h50400, first invalid byte.
REQ-005 clk_sys  in  1  system clock; one clock domain only, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ioctl_download  in  1  download in progress; qualified internally with ioctl_index==0.
REQ-008 ioctl_index  in  8  0 = ROM image, 254 = DIP bytes; other values ignored.
REQ-009 ioctl_wr  in  1  one-cycle word write strobe.
REQ-010 ioctl_addr  in  27  byte address of word (bit 0 always 0).
REQ-011 ioctl_dout  in  16  data word; [7:0] at even byte, [15:8] at odd byte.
REQ-012 ioctl_wait  out  1  stall request to HPS while word is split.
REQ-013 rom_addr  out  18  byte address relative to selected region base.
REQ-014 rom_data  out  8  byte to write.
REQ-015 rom_we  out  1  one-cycle byte write strobe.
REQ-016 rom_sel  out  4  one-hot region select {pal,gfx,snd,cpu}, valid with rom_we.
REQ-017 dsw0, dsw1  out  8 each  captured DIP bytes 0 and 1.
REQ-018 load_done  out  1  ROM image fully received.
REQ-019 core_reset  out  1  reset for game core.

Function
REQ-020 FSM states IDLE, WR_LO, WR_HI; reset state IDLE.
REQ-021 IDLE: ioctl_wr with index 0 and download high latches addr/data, asserts ioctl_wait same cycle as latch (registered next cycle), goes WR_LO.
REQ-022 WR_LO: rom_we=1, byte = latched[7:0], address = latched addr; go WR_HI.
REQ-023 WR_HI: rom_we=1, byte = latched[15:8], address = latched addr+1; go IDLE, ioctl_wait deasserts next cycle.
REQ-024 Latency: first byte strobe 1 cycle after ioctl_wr; exactly two rom_we pulses per word; ioctl_wait high for exactly 2 cycles per word.
REQ-025 Region decode: addr<SND_BASE cpu, <GFX_BASE snd, <PAL_BASE gfx, <END_ADDR pal; rom_addr = addr − base, truncated to 18 bits.
REQ-026 Addresses >= END_ADDR: FSM still runs and ioctl_wait still pulses, but rom_we stays 0 and rom_sel 0.
REQ-027 ioctl_wr arriving while FSM not IDLE is ignored (HPS contract forbids it; no queueing).
REQ-028 Index 254 write with addr[24:3]==0: addr[2:0]==0 loads dsw0<=dout[7:0], ==1 loads dsw1<=dout[7:0]; no FSM activity, no ioctl_wait.
REQ-029 load_done sets on falling edge of (download & index==0) once FSM is IDLE; clears on rising edge of a new ROM download.
REQ-030 core_reset = reset | ~load_done | ROM download active | FSM not IDLE, registered.
REQ-031 Download deasserted while in WR_LO/WR_HI: pending bytes still complete; load_done sets after return to IDLE.

Reset
REQ-032 On reset: FSM IDLE, ioctl_wait 0, rom_we 0, rom_sel 0, rom_addr 0, rom_data 0, load_done 0, core_reset 1, dsw0/dsw1 8'hFF.
REQ-033 Reset mid-word abandons remaining byte; no rom_we after reset cycle.

Structure
REQ-034 Package loader_pkg holds FSM state enum, region index constants, default base parameters, ROM/DIP index constants (0, 254).
REQ-035 One sub-module rom_region_decode: combinational address-to-{rom_sel, rom_addr, valid}.

Verification
REQ-036 Word 16'hA55A at addr 0x00010 -> rom_we pulses cycles 1,2: (sel cpu, 0x10, 5A) then (0x11, A5); ioctl_wait high 2 cycles.
REQ-037 Word at 0x18002 -> sel gfx, rom_addr 0x00002/0x00003; word at 0x503FE -> sel pal, 0x3FE/0x3FF.
REQ-038 Word at 0x50400 -> no rom_we, ioctl_wait still 2 cycles.
REQ-039 Index 254, addr 0/1, dout 0x0012/0x0034 -> dsw0=12, dsw1=34; ioctl_wait never high.
REQ-040 Download drops during WR_LO -> WR_HI byte written, load_done high next cycle after IDLE, core_reset low one cycle later.
REQ-041 reset in WR_LO -> next cycle FSM IDLE, rom_we 0, ioctl_wait 0, dsw 8'hFF, load_done 0.
